// File: rtl/cache_pkg.sv
// Shared types and address-split width helpers for the set-associative cache.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB,
      ST_FILL,
      ST_FLUSH_SCAN,
      ST_FLUSH_WB
   } state_e;

   // Way-number width; a direct-mapped cache still carries a 1-bit way field.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   // Byte offset inside a line.
   function automatic int offset_bits(input int linewords, input int wordbits);
      return $clog2(linewords * wordbits / 8);
   endfunction

   // Byte offset inside a word.
   function automatic int byte_bits(input int wordbits);
      return $clog2(wordbits / 8);
   endfunction

   // Word offset inside a line.
   function automatic int word_bits(input int linewords);
      return $clog2(linewords);
   endfunction

   function automatic int tag_bits(input int addressbits, input int sets,
                                   input int linewords, input int wordbits);
      return addressbits - index_bits(sets) - offset_bits(linewords, wordbits);
   endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping: per-set age counters, victim choice with invalid-way priority.
module cache_lru
   import cache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 512
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [index_bits(SETS)-1:0] set_idx,
   input  logic [WAYS-1:0]             valid_vec,
   input  logic                        touch,
   input  logic [way_bits(WAYS)-1:0]   touch_way,
   output logic [way_bits(WAYS)-1:0]   victim_way
);

   localparam int WAY_W = way_bits(WAYS);

   if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] age_d [SETS][WAYS];
      logic [WAY_W-1:0] old_age;
      logic [WAY_W-1:0] inv_way;
      logic [WAY_W-1:0] lru_way;
      logic             any_invalid;

      // Age update: younger-than-hit ways grow one step older, the hit way becomes MRU.
      always_comb begin
         // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
         age_d   = age_q;
         old_age = age_q[set_idx][touch_way];
         if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
               if (age_q[set_idx][w] < old_age) begin
                  age_d[set_idx][w] = age_q[set_idx][w] + WAY_W'(1);
               end
            end
            age_d[set_idx][touch_way] = '0;
         end
      end

      // Victim choice: lowest-index invalid way first, otherwise the oldest way.
      always_comb begin
         inv_way     = '0;
         any_invalid = 1'b0;
         lru_way     = '0;
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
               inv_way     = WAY_W'(w);
               any_invalid = 1'b1;
            end
            if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) begin
               lru_way = WAY_W'(w);
            end
         end
         victim_way = any_invalid ? inv_way : lru_way;
      end

      // Age registers; reset makes way index equal to age so each set starts as a permutation.
      always_ff @(posedge CLK) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         if (RESET) begin
            for (int s = 0; s < SETS; s++) begin
               for (int w = 0; w < WAYS; w++) begin
                  age_q[s][w] <= WAY_W'(w);
               end
            end
         end else begin
            age_q <= age_d;
         end
      end
   end else begin : g_direct
      logic unused_ok;
      assign unused_ok  = ^{CLK, RESET, set_idx, valid_vec, touch, touch_way};
      assign victim_way = '0;
   end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with true-LRU and explicit flush.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int WAYS        = 2,
   parameter int SETS        = 512,
   parameter int LINEWORDS   = 8,
   parameter int ADDRESSBITS = 32,
   parameter int WORDBITS    = 32
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            Read1,
   input  logic                            Write1,
   input  logic                            Flush1,
   input  logic [ADDRESSBITS-1:0]          Address1,
   input  logic [WORDBITS-1:0]             WriteData1,
   input  logic [WORDBITS/8-1:0]           ByteEn1,
   output logic [WORDBITS-1:0]             ReadData1,
   output logic                            OperationAccepted1,
   output logic                            read_2DM,
   output logic                            write_2DM,
   output logic [ADDRESSBITS-1:0]          address_2DM,
   output logic [LINEWORDS*WORDBITS-1:0]   data_2DM,
   input  logic [LINEWORDS*WORDBITS-1:0]   data_fDM,
   input  logic                            dm_operation_accepted
);

   localparam int IDX_W     = index_bits(SETS);
   localparam int OFF_W     = offset_bits(LINEWORDS, WORDBITS);
   localparam int BYTE_W    = byte_bits(WORDBITS);
   localparam int WORD_W    = word_bits(LINEWORDS);
   localparam int TAG_W     = tag_bits(ADDRESSBITS, SETS, LINEWORDS, WORDBITS);
   localparam int WAY_W     = way_bits(WAYS);
   localparam int WAY_SH    = $clog2(WAYS);
   localparam int LINES     = WAYS * SETS;
   localparam int LINE_W    = $clog2(LINES);
   localparam int LINE_BITS = LINEWORDS * WORDBITS;
   localparam int NBYTES    = WORDBITS / 8;

   typedef logic [LINE_BITS-1:0] line_t;

   state_e              state_q, state_d;
   logic                ack_q, ack_d;
   logic [WORDBITS-1:0] rdata_q, rdata_d;
   logic [WAY_W-1:0]    victim_q, victim_d;
   logic [LINE_W-1:0]   flush_idx_q, flush_idx_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [LINES-1:0]    dirty_q, dirty_d;

   logic [TAG_W-1:0]    tag_q  [LINES];
   line_t               data_q [LINES];

   logic                data_we, tag_we;
   logic [LINE_W-1:0]   data_wline, tag_wline;
   line_t               data_wdata;
   logic [TAG_W-1:0]    tag_wdata;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_set, flush_set;
   logic [WORD_W-1:0]   req_word;
   logic                hit;
   logic [WAY_W-1:0]    hit_way, lru_victim;
   logic [WAYS-1:0]     set_valid;
   logic [LINE_W-1:0]   hit_line, victim_line;
   line_t               merged_line;
   logic [WORDBITS-1:0] hit_word;
   logic                lru_touch;

   // Flat line number of (set, way); flush walks lines in this order.
   function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] s,
                                                  input logic [WAY_W-1:0] w);
      return LINE_W'(int'(s) * WAYS + int'(w));
   endfunction

   assign req_tag     = Address1[ADDRESSBITS-1 -: TAG_W];
   assign req_set     = Address1[OFF_W +: IDX_W];
   assign req_word    = Address1[BYTE_W +: WORD_W];
   assign hit_line    = line_of(req_set, hit_way);
   assign victim_line = line_of(req_set, victim_q);
   assign flush_set   = IDX_W'(flush_idx_q >> WAY_SH);
   assign hit_word    = data_q[hit_line][int'(req_word)*WORDBITS +: WORDBITS];

   // Sub-word address bits carry no information for word-aligned accesses.
   if (BYTE_W > 0) begin : g_byte_off
      logic unused_ok;
      assign unused_ok = ^Address1[BYTE_W-1:0];
   end

   // Tag compare across the ways of the addressed set.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      set_valid = '0;
      for (int w = 0; w < WAYS; w++) begin
         set_valid[w] = valid_q[line_of(req_set, WAY_W'(w))];
         if (!hit && set_valid[w] && tag_q[line_of(req_set, WAY_W'(w))] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Byte-enable merge of the write data into the hit line.
   always_comb begin
      merged_line = data_q[hit_line];
      for (int b = 0; b < NBYTES; b++) begin
         if (ByteEn1[b]) begin
            merged_line[int'(req_word)*WORDBITS + 8*b +: 8] = WriteData1[8*b +: 8];
         end
      end
   end

   cache_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .CLK        (CLK),
      .RESET      (RESET),
      .set_idx    (req_set),
      .valid_vec  (set_valid),
      .touch      (lru_touch),
      .touch_way  (hit_way),
      .victim_way (lru_victim)
   );

   // Controller next state, array write ports and memory-port outputs.
   always_comb begin
      state_d     = state_q;
      ack_d       = 1'b0;
      rdata_d     = rdata_q;
      victim_d    = victim_q;
      flush_idx_d = flush_idx_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      data_we     = 1'b0;
      data_wline  = hit_line;
      data_wdata  = merged_line;
      tag_we      = 1'b0;
      tag_wline   = victim_line;
      tag_wdata   = req_tag;
      lru_touch   = 1'b0;
      read_2DM    = 1'b0;
      write_2DM   = 1'b0;
      address_2DM = '0;
      data_2DM    = '0;
      unique case (state_q)
         ST_IDLE: begin
            // The cycle that shows the completion pulse ignores the still-held request.
            if (!ack_q) begin
               if (Flush1) begin
                  state_d     = ST_FLUSH_SCAN;
                  flush_idx_d = '0;
               end else if (Write1 || Read1) begin
                  if (hit) begin
                     ack_d     = 1'b1;
                     lru_touch = 1'b1;
                     if (Write1) begin
                        data_we           = 1'b1;
                        dirty_d[hit_line] = 1'b1;
                     end else begin
                        rdata_d = hit_word;
                     end
                  end else begin
                     victim_d = lru_victim;
                     state_d  = dirty_q[line_of(req_set, lru_victim)] ? ST_WB : ST_FILL;
                  end
               end
            end
         end
         ST_WB: begin
            write_2DM   = 1'b1;
            address_2DM = {tag_q[victim_line], req_set, OFF_W'(0)};
            data_2DM    = data_q[victim_line];
            if (dm_operation_accepted) begin
               dirty_d[victim_line] = 1'b0;
               state_d              = ST_FILL;
            end
         end
         ST_FILL: begin
            read_2DM    = 1'b1;
            address_2DM = {req_tag, req_set, OFF_W'(0)};
            if (dm_operation_accepted) begin
               data_we              = 1'b1;
               data_wline           = victim_line;
               data_wdata           = data_fDM;
               tag_we               = 1'b1;
               valid_d[victim_line] = 1'b1;
               dirty_d[victim_line] = 1'b0;
               state_d              = ST_IDLE;
            end
         end
         ST_FLUSH_SCAN: begin
            if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
               state_d = ST_FLUSH_WB;
            end else begin
               valid_d[flush_idx_q] = 1'b0;
               dirty_d[flush_idx_q] = 1'b0;
               if (flush_idx_q == LINE_W'(LINES - 1)) begin
                  ack_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  flush_idx_d = flush_idx_q + LINE_W'(1);
               end
            end
         end
         ST_FLUSH_WB: begin
            write_2DM   = 1'b1;
            address_2DM = {tag_q[flush_idx_q], flush_set, OFF_W'(0)};
            data_2DM    = data_q[flush_idx_q];
            if (dm_operation_accepted) begin
               dirty_d[flush_idx_q] = 1'b0;
               state_d              = ST_FLUSH_SCAN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and status registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         victim_q    <= '0;
         flush_idx_q <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         victim_q    <= victim_d;
         flush_idx_q <= flush_idx_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Tag and data storage.
   always_ff @(posedge CLK) begin
      // NOTE: storage arrays are not reset; valid bits alone decide whether their contents matter.
      if (data_we) begin
         data_q[data_wline] <= data_wdata;
      end
      if (tag_we) begin
         tag_q[tag_wline] <= tag_wdata;
      end
   end

   assign ReadData1          = rdata_q;
   assign OperationAccepted1 = ack_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench: 2-way, 4-set, 4-word lines, memory answering 3 cycles after a request.
module tb_set_assoc_cache;

   localparam int WAYS = 2;
   localparam int SETS = 4;
   localparam int LW   = 4;
   localparam int AB   = 32;
   localparam int WB   = 32;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            Read1, Write1, Flush1;
   logic [AB-1:0]   Address1;
   logic [WB-1:0]   WriteData1;
   logic [WB/8-1:0] ByteEn1;
   logic [WB-1:0]   ReadData1;
   logic            OperationAccepted1;
   logic            read_2DM, write_2DM;
   logic [AB-1:0]   address_2DM;
   logic [LW*WB-1:0] data_2DM;
   logic [LW*WB-1:0] data_fDM;
   logic            dm_operation_accepted;

   int checks   = 0;
   int failures = 0;

   // Memory model state.
   logic [LW*WB-1:0] mem [logic [31:0]];
   int               mem_cnt  = 0;
   int               rd_beats = 0;
   int               wb_beats = 0;
   logic [31:0]      last_rd_addr = '0;
   logic [31:0]      last_wb_addr = '0;

   always #5 CLK = ~CLK;

   set_assoc_cache #(
      .WAYS        (WAYS),
      .SETS        (SETS),
      .LINEWORDS   (LW),
      .ADDRESSBITS (AB),
      .WORDBITS    (WB)
   ) dut (
      .CLK                   (CLK),
      .RESET                 (RESET),
      .Read1                 (Read1),
      .Write1                (Write1),
      .Flush1                (Flush1),
      .Address1              (Address1),
      .WriteData1            (WriteData1),
      .ByteEn1               (ByteEn1),
      .ReadData1             (ReadData1),
      .OperationAccepted1    (OperationAccepted1),
      .read_2DM              (read_2DM),
      .write_2DM             (write_2DM),
      .address_2DM           (address_2DM),
      .data_2DM              (data_2DM),
      .data_fDM              (data_fDM),
      .dm_operation_accepted (dm_operation_accepted)
   );

   // Background contents of a never-written line: word i = 0xC0000000 | (addr + 4*i).
   function automatic logic [LW*WB-1:0] pattern_line(input logic [31:0] a);
      logic [LW*WB-1:0] l;
      for (int i = 0; i < LW; i++) begin
         l[32*i +: 32] = 32'hC000_0000 | (a + 32'(4 * i));
      end
      return l;
   endfunction

   // Memory: counts three falling edges of a request, then pulses accept for one cycle.
   always @(negedge CLK) begin
      if (read_2DM && write_2DM) begin
         failures++;
         $display("FAIL mem_port_overlap: read_2DM=%0b write_2DM=%0b, required never both 1",
                  read_2DM, write_2DM);
      end
      if (RESET) begin
         dm_operation_accepted = 1'b0;
         mem_cnt               = 0;
      end else if (dm_operation_accepted) begin
         dm_operation_accepted = 1'b0;
         mem_cnt               = 0;
      end else if (read_2DM || write_2DM) begin
         mem_cnt++;
         if (mem_cnt == 3) begin
            dm_operation_accepted = 1'b1;
            if (write_2DM) begin
               mem[address_2DM] = data_2DM;
               wb_beats++;
               last_wb_addr = address_2DM;
            end else begin
               rd_beats++;
               last_rd_addr = address_2DM;
               data_fDM = mem.exists(address_2DM) ? mem[address_2DM] : pattern_line(address_2DM);
            end
         end
      end
   end

   // Issues one request (driven just after a rising edge), waits for the completion pulse,
   // then spends the pulse cycle with the request still held when hold=1.
   task automatic do_op(input logic rd, input logic wr, input logic fl,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input bit hold, output int cyc, output logic [31:0] data,
                        output logic extra);
      Read1 = rd; Write1 = wr; Flush1 = fl;
      Address1 = a; WriteData1 = wd; ByteEn1 = be;
      cyc = 0;
      while (!OperationAccepted1 && cyc < 400) begin
         @(posedge CLK); #1;
         cyc++;
      end
      data = ReadData1;
      if (!OperationAccepted1) begin
         checks++; failures++;
         $display("FAIL op_timeout: addr=0x%08h no OperationAccepted1 after %0d cycles", a, cyc);
      end
      if (!hold) begin
         Read1 = 1'b0; Write1 = 1'b0; Flush1 = 1'b0;
      end
      @(posedge CLK); #1;
      extra = OperationAccepted1;
      Read1 = 1'b0; Write1 = 1'b0; Flush1 = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (OperationAccepted1 !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", OperationAccepted1); end
      checks++; if (read_2DM !== 1'b0) begin failures++; $display("FAIL reset_read_2DM: got %b expected 0", read_2DM); end
      checks++; if (write_2DM !== 1'b0) begin failures++; $display("FAIL reset_write_2DM: got %b expected 0", write_2DM); end
      checks++; if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_rdata: got 0x%08h expected 0x00000000", ReadData1); end
      checks++; if (address_2DM !== 32'h0) begin failures++; $display("FAIL reset_address_2DM: got 0x%08h expected 0x00000000", address_2DM); end
      RESET = 1'b0;
   endtask

   task automatic test_read_miss();
      int cyc; logic [31:0] d; logic x;
      do_op(1, 0, 0, 32'h40, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 5) begin failures++; $display("FAIL miss_latency: got %0d cycles expected 5", cyc); end
      checks++; if (d !== 32'hC000_0040) begin failures++; $display("FAIL miss_rdata: got 0x%08h expected 0xC0000040", d); end
      checks++; if (rd_beats !== 1) begin failures++; $display("FAIL miss_fill_count: got %0d expected 1", rd_beats); end
      checks++; if (last_rd_addr !== 32'h40) begin failures++; $display("FAIL miss_fill_addr: got 0x%08h expected 0x00000040", last_rd_addr); end
      checks++; if (wb_beats !== 0) begin failures++; $display("FAIL miss_wb_count: got %0d expected 0", wb_beats); end
   endtask

   task automatic test_write_hit();
      int cyc; logic [31:0] d; logic x;
      do_op(0, 1, 0, 32'h44, 32'hDEAD_BEEF, 4'b0011, 0, cyc, d, x);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL write_hit_latency: got %0d expected 1", cyc); end
      do_op(1, 0, 0, 32'h44, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL read_hit_latency: got %0d expected 1", cyc); end
      checks++; if (d !== 32'hC000_BEEF) begin failures++; $display("FAIL byte_merge: got 0x%08h expected 0xC000BEEF", d); end
   endtask

   task automatic test_evict();
      int cyc; logic [31:0] d; logic x;
      do_op(1, 0, 0, 32'h80, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 5 || d !== 32'hC000_0080) begin failures++; $display("FAIL fill_0x80: got %0d cycles data 0x%08h expected 5 cycles data 0xC0000080", cyc, d); end
      do_op(1, 0, 0, 32'hC0, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 9) begin failures++; $display("FAIL wb_fill_latency: got %0d expected 9", cyc); end
      checks++; if (wb_beats !== 1 || last_wb_addr !== 32'h40) begin failures++; $display("FAIL victim_wb: got %0d beats addr 0x%08h expected 1 beat addr 0x00000040", wb_beats, last_wb_addr); end
      checks++; if (rd_beats !== 3 || last_rd_addr !== 32'hC0) begin failures++; $display("FAIL victim_fill: got %0d beats addr 0x%08h expected 3 beats addr 0x000000C0", rd_beats, last_rd_addr); end
      checks++; if (d !== 32'hC000_00C0) begin failures++; $display("FAIL rdata_0xC0: got 0x%08h expected 0xC00000C0", d); end
      do_op(1, 0, 0, 32'h80, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL mru_survives: got %0d cycles expected 1", cyc); end
      do_op(1, 0, 0, 32'h44, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 5 || d !== 32'hC000_BEEF) begin failures++; $display("FAIL wb_data_refetch: got %0d cycles data 0x%08h expected 5 cycles data 0xC000BEEF", cyc, d); end
   endtask

   task automatic test_flush();
      int cyc; int wb0; logic [31:0] d; logic x;
      do_op(0, 1, 0, 32'h48, 32'h1111_1111, 4'hF, 0, cyc, d, x);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL dirty_hit_0x48: got %0d cycles expected 1", cyc); end
      do_op(0, 1, 0, 32'h10, 32'h1234_5678, 4'hF, 0, cyc, d, x);
      checks++; if (cyc !== 5) begin failures++; $display("FAIL write_miss_0x10: got %0d cycles expected 5", cyc); end
      wb0 = wb_beats;
      do_op(0, 0, 1, 32'h0, 32'h0, 4'h0, 1, cyc, d, x);
      checks++; if (cyc !== 17) begin failures++; $display("FAIL flush_latency: got %0d cycles expected 17", cyc); end
      checks++; if (wb_beats - wb0 !== 2) begin failures++; $display("FAIL flush_wb_count: got %0d expected 2", wb_beats - wb0); end
      checks++; if (x !== 1'b0) begin failures++; $display("FAIL flush_single_ack: got %b expected 0", x); end
      do_op(1, 0, 0, 32'h80, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 5 || d !== 32'hC000_0080) begin failures++; $display("FAIL post_flush_miss: got %0d cycles data 0x%08h expected 5 cycles data 0xC0000080", cyc, d); end
      do_op(1, 0, 0, 32'h10, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 5 || d !== 32'h1234_5678) begin failures++; $display("FAIL flush_wb_data: got %0d cycles data 0x%08h expected 5 cycles data 0x12345678", cyc, d); end
   endtask

   task automatic test_reset_mid_fill();
      int cyc; int rd0; int n; logic [31:0] d; logic x;
      Read1 = 1'b1; Address1 = 32'h200;
      n = 0;
      while (!read_2DM && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      checks++; if (read_2DM !== 1'b1) begin failures++; $display("FAIL fill_start: got read_2DM=%b expected 1", read_2DM); end
      Read1 = 1'b0; RESET = 1'b1;
      @(posedge CLK); #1;
      checks++; if (read_2DM !== 1'b0) begin failures++; $display("FAIL reset_drops_fill: got read_2DM=%b expected 0", read_2DM); end
      RESET = 1'b0;
      rd0 = rd_beats;
      do_op(1, 0, 0, 32'h200, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (cyc !== 5 || d !== 32'hC000_0200) begin failures++; $display("FAIL refetch_after_reset: got %0d cycles data 0x%08h expected 5 cycles data 0xC0000200", cyc, d); end
      checks++; if (rd_beats - rd0 !== 1) begin failures++; $display("FAIL refetch_count: got %0d expected 1", rd_beats - rd0); end
   endtask

   task automatic test_back_to_back();
      int cyc; int wb0; logic [31:0] d; logic x;
      do_op(1, 1, 0, 32'h200, 32'h0000_00AA, 4'b0001, 1, cyc, d, x);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL held_rw_latency: got %0d cycles expected 1", cyc); end
      checks++; if (x !== 1'b0) begin failures++; $display("FAIL held_rw_single_ack: got %b expected 0", x); end
      wb0 = wb_beats;
      do_op(0, 0, 1, 32'h0, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (wb_beats - wb0 !== 1) begin failures++; $display("FAIL held_rw_dirty_count: got %0d expected 1", wb_beats - wb0); end
      do_op(1, 0, 0, 32'h200, 32'h0, 4'h0, 0, cyc, d, x);
      checks++; if (d !== 32'hC000_02AA) begin failures++; $display("FAIL held_rw_data: got 0x%08h expected 0xC00002AA", d); end
   endtask

   initial begin
      Read1 = 1'b0; Write1 = 1'b0; Flush1 = 1'b0;
      Address1 = '0; WriteData1 = '0; ByteEn1 = '0;
      dm_operation_accepted = 1'b0; data_fDM = '0;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_evict();
      test_flush();
      test_reset_mid_fill();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
